// File: rtl/sram_burst_arbiter.sv
// Two-requester burst arbiter for the counter-addressed SRAM pair: grants one burst, resets the
// address counter, then steps it per word with fixed settle/strobe timing. Option: SRAM_ARB_FIXED_PRIO_EN.
module sram_burst_arbiter #(
  parameter int unsigned DW         = 8,
  parameter int unsigned CW         = 12,
  parameter int unsigned REL_CYC    = 100,
  parameter int unsigned SETTLE_CYC = 500,
  parameter int unsigned WE_CYC     = 500,
  parameter int unsigned LOW_CYC    = 500
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    REQ,
  input  logic [1:0]    OP,
  input  logic [CW-1:0] LEN0,
  input  logic [CW-1:0] LEN1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic [1:0]    GNT,
  output logic          WD_ACK,
  output logic [DW-1:0] RDATA,
  output logic          RD_VALID,
  output logic          DONE,
  output logic          BUSY,
  output logic          COUNTER_CLK,
  output logic          COUNTER_RST,
  output logic          WE_BAR,
  output logic [DW-1:0] DQ_OUT,
  output logic          DQ_OE,
  input  logic [DW-1:0] DQ_IN
);

  localparam int unsigned REL_N = (REL_CYC    == 0) ? 1 : REL_CYC;
  localparam int unsigned SET_N = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam int unsigned WE_N  = (WE_CYC     == 0) ? 1 : WE_CYC;
  localparam int unsigned LOW_N = (LOW_CYC    == 0) ? 1 : LOW_CYC;

  localparam logic [15:0] REL_LD = 16'(REL_N - 1);
  localparam logic [15:0] SET_LD = 16'(SET_N - 1);
  localparam logic [15:0] WE_LD  = 16'(WE_N - 1);
  localparam logic [15:0] LOW_LD = 16'(LOW_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REL, S_SETTLE, S_ACCESS, S_STEP, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] len_q, len_d;
  logic          wr_q, wr_d;
  logic          win_q, win_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          wd_ack_q, wd_ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          cclk_q, cclk_d;
  logic          crst_q, crst_d;
  logic          we_bar_q, we_bar_d;
  logic [DW-1:0] dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          pick;
  logic [DW-1:0] wdata_sel;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = ~REQ[0];
  end
`else
  logic rr_q, rr_d;

  always_comb begin
    pick = (&REQ) ? rr_q : REQ[1];
  end

  always_ff @(posedge CLK) begin
    if (RST) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  assign wdata_sel = win_q ? WDATA1 : WDATA0;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    len_d      = len_q;
    wr_d       = wr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    wd_ack_d   = 1'b0;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    cclk_d     = cclk_q;
    crst_d     = crst_q;
    we_bar_d   = we_bar_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        crst_d = 1'b1;
        if (|REQ) begin
          win_d   = pick;
          wr_d    = OP[pick];
          len_d   = pick ? LEN1 : LEN0;
          gnt_d   = pick ? 2'b10 : 2'b01;
          idx_d   = '0;
          timer_d = REL_LD;
          crst_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (timer_q == '0) begin
          timer_d = SET_LD;
          state_d = S_SETTLE;
          if (wr_q) begin
            dq_oe_d  = 1'b1;
            dq_out_d = wdata_sel;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_SETTLE: begin
        // Keep following the winner's data until the strobe starts.
        if (wr_q) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_sel;
        end
        if (timer_q == '0) begin
          timer_d  = WE_LD;
          we_bar_d = ~wr_q;
          state_d  = S_ACCESS;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_ACCESS: begin
        if (timer_q == '0) begin
          we_bar_d = 1'b1;
          if (wr_q) begin
            wd_ack_d = 1'b1;
          end else begin
            rdata_d    = DQ_IN;
            rd_valid_d = 1'b1;
          end
          if (idx_q == len_q) begin
            dq_oe_d = 1'b0;
            state_d = S_FIN;
          end else begin
            // Data stays driven through the first low cycle to give the SRAM hold time.
            dq_oe_d = wr_q;
            cclk_d  = 1'b0;
            timer_d = LOW_LD;
            state_d = S_STEP;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STEP: begin
        dq_oe_d = 1'b0;
        if (timer_q == '0) begin
          cclk_d  = 1'b1;
          idx_d   = idx_q + 1'b1;
          timer_d = SET_LD;
          state_d = S_SETTLE;
          if (wr_q) begin
            dq_oe_d  = 1'b1;
            dq_out_d = wdata_sel;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        gnt_d   = 2'b00;
        crst_d  = 1'b1;
        busy_d  = 1'b0;
        dq_oe_d = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        rr_d    = ~win_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      win_q      <= 1'b0;
      gnt_q      <= 2'b00;
      wd_ack_q   <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cclk_q     <= 1'b1;
      crst_q     <= 1'b1;
      we_bar_q   <= 1'b1;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      wd_ack_q   <= wd_ack_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cclk_q     <= cclk_d;
      crst_q     <= crst_d;
      we_bar_q   <= we_bar_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign GNT         = gnt_q;
  assign WD_ACK      = wd_ack_q;
  assign RDATA       = rdata_q;
  assign RD_VALID    = rd_valid_q;
  assign DONE        = done_q;
  assign BUSY        = busy_q;
  assign COUNTER_CLK = cclk_q;
  assign COUNTER_RST = crst_q;
  assign WE_BAR      = we_bar_q;
  assign DQ_OUT      = dq_out_q;
  assign DQ_OE       = dq_oe_q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Scoreboard bench for sram_burst_arbiter with a behavioural counter + SRAM model on the pins.
module tb_sram_burst_arbiter;

  localparam int K_GNT  = 0;
  localparam int K_WD   = 1;
  localparam int K_RD   = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int val;
    int lat;
    int falls;
    int welow;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] REQ = 2'b11;
  logic [1:0] OP  = 2'b00;
  logic [3:0] LEN0 = '0, LEN1 = '0;
  logic [7:0] WDATA0 = '0, WDATA1 = '0;
  logic [1:0] GNT;
  logic       WD_ACK, RD_VALID, DONE, BUSY, COUNTER_CLK, COUNTER_RST, WE_BAR, DQ_OE;
  logic [7:0] RDATA, DQ_OUT, DQ_IN;

  int compared = 0;
  int failed   = 0;
  exp_t sb[$];

  logic [7:0] mem [16];
  logic [3:0] addr = '0;
  logic       cclk_prev = 1'b1;
  logic [7:0] wd0 [4];
  int         widx0 = 0;

  sram_burst_arbiter #(.DW(8), .CW(4), .REL_CYC(2), .SETTLE_CYC(2), .WE_CYC(3), .LOW_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .LEN0(LEN0), .LEN1(LEN1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .GNT(GNT), .WD_ACK(WD_ACK), .RDATA(RDATA),
    .RD_VALID(RD_VALID), .DONE(DONE), .BUSY(BUSY), .COUNTER_CLK(COUNTER_CLK),
    .COUNTER_RST(COUNTER_RST), .WE_BAR(WE_BAR), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQ_IN(DQ_IN)
  );

  always #5 CLK = ~CLK;

  // External MC14040B-style counter (advances on COUNTER_CLK fall) and SRAM.
  always @(posedge CLK) begin
    if (COUNTER_RST) addr <= '0;
    else if (cclk_prev && !COUNTER_CLK) addr <= addr + 4'd1;
    cclk_prev <= COUNTER_CLK;
    if (!WE_BAR) mem[addr] <= DQ_OUT;
  end
  assign DQ_IN = DQ_OE ? DQ_OUT : mem[addr];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: actual 'h%0h required 'h%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val, input int lat, input int falls, input int welow);
    exp_t e;
    e.kind = kind; e.val = val; e.lat = lat; e.falls = falls; e.welow = welow;
    sb.push_back(e);
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e = '{default: 0};
    if (sb.size() == 0) begin
      compared++; failed++;
      $display("FAIL unexpected_event: actual kind %0d required none", kind);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  // Write-data driver: present the next word after each WD_ACK.
  initial begin
    logic [1:0] pg = 2'b00;
    forever begin
      @(negedge CLK);
      if (GNT != 2'b00 && pg == 2'b00) widx0 = 0;
      else if (WD_ACK && GNT[0] && widx0 < 3) widx0++;
      WDATA0 = wd0[widx0];
      pg = GNT;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic [1:0] pg = 2'b00;
    logic       pc = 1'b1;
    int lat = 0, falls = 0, welow = 0, ovl = 0;
    exp_t e;
    bit ok;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pg = 2'b00; pc = 1'b1; lat = 0;
      end else begin
        if (GNT != 2'b00 && pg == 2'b00) begin
          lat = 0; falls = 0; welow = 0; ovl = 0;
          take(K_GNT, e, ok);
          if (ok) check("gnt", int'(GNT), e.val);
        end else begin
          lat++;
        end
        if (pc && !COUNTER_CLK) falls++;
        if (!WE_BAR) welow++;
        if (!WE_BAR && !COUNTER_CLK) ovl++;
        if (WD_ACK) begin
          take(K_WD, e, ok);
          if (ok) check("wd_ack_addr", int'(addr), e.val);
        end
        if (RD_VALID) begin
          take(K_RD, e, ok);
          if (ok) check("rdata", int'(RDATA), e.val);
        end
        if (DONE) begin
          take(K_DONE, e, ok);
          if (ok) begin
            check("done_latency", lat, e.lat);
            check("counter_falls", falls, e.falls);
            check("we_low_cycles", welow, e.welow);
            check("we_low_during_clk_low", ovl, 0);
          end
        end
        pg = GNT; pc = COUNTER_CLK;
      end
    end
  end

  task automatic wait_gnt(input string name);
    int n = 0;
    do begin @(negedge CLK); n++; end while (GNT == 2'b00 && n < 2000);
    if (GNT == 2'b00) begin
      compared++; failed++;
      $display("FAIL %s: actual no grant required grant within 2000 cycles", name);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!DONE && n < 2000);
    if (!DONE) begin
      compared++; failed++;
      $display("FAIL %s: actual no DONE required DONE within 2000 cycles", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, int'(GNT), 0);
    check({tag, "_wd_ack"}, int'(WD_ACK), 0);
    check({tag, "_rdata"}, int'(RDATA), 0);
    check({tag, "_rd_valid"}, int'(RD_VALID), 0);
    check({tag, "_done"}, int'(DONE), 0);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_counter_clk"}, int'(COUNTER_CLK), 1);
    check({tag, "_counter_rst"}, int'(COUNTER_RST), 1);
    check({tag, "_we_bar"}, int'(WE_BAR), 1);
    check({tag, "_dq_oe"}, int'(DQ_OE), 0);
    check({tag, "_dq_out"}, int'(DQ_OUT), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) wd0[i] = '0;

    // Reset with both requests held.
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    @(negedge CLK);
    check("reset_hold_gnt", int'(GNT), 0);
    REQ = 2'b00;
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Requester 0 writes four words: lat = 2 + 4*(2+3) + 3*2 + 1 = 29.
    wd0[0] = 8'hA5; wd0[1] = 8'h3C; wd0[2] = 8'hF0; wd0[3] = 8'h0F;
    OP = 2'b01; LEN0 = 4'd3;
    push(K_GNT, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(K_WD, i, 0, 0, 0);
    push(K_DONE, 0, 29, 3, 12);
    REQ = 2'b01;
    wait_gnt("wr4_grant");
    REQ = 2'b00;
    wait_done("wr4_done");
    check("mem0", int'(mem[0]), 8'hA5);
    check("mem1", int'(mem[1]), 8'h3C);
    check("mem2", int'(mem[2]), 8'hF0);
    check("mem3", int'(mem[3]), 8'h0F);
    repeat (2) @(negedge CLK);

    // Requester 1 reads them back.
    OP = 2'b00; LEN1 = 4'd3;
    push(K_GNT, 2, 0, 0, 0);
    push(K_RD, 8'hA5, 0, 0, 0);
    push(K_RD, 8'h3C, 0, 0, 0);
    push(K_RD, 8'hF0, 0, 0, 0);
    push(K_RD, 8'h0F, 0, 0, 0);
    push(K_DONE, 0, 29, 3, 0);
    REQ = 2'b10;
    wait_gnt("rd4_grant");
    REQ = 2'b00;
    wait_done("rd4_done");
    repeat (2) @(negedge CLK);

    // Both requesting, single-word reads, back-to-back grants.
    OP = 2'b00; LEN0 = 4'd0; LEN1 = 4'd0;
    push(K_GNT, 1, 0, 0, 0);
    push(K_RD, 8'hA5, 0, 0, 0);
    push(K_DONE, 0, 8, 0, 0);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    push(K_GNT, 1, 0, 0, 0);
`else
    push(K_GNT, 2, 0, 0, 0);
`endif
    push(K_RD, 8'hA5, 0, 0, 0);
    push(K_DONE, 0, 8, 0, 0);
    REQ = 2'b11;
    wait_gnt("both_grant1");
    wait_done("both_done1");
    wait_gnt("both_grant2");
    REQ = 2'b00;
    wait_done("both_done2");
    repeat (2) @(negedge CLK);

    // Single-word write: DONE 8 cycles after grant, no counter step.
    wd0[0] = 8'h77;
    OP = 2'b01; LEN0 = 4'd0;
    push(K_GNT, 1, 0, 0, 0);
    push(K_WD, 0, 0, 0, 0);
    push(K_DONE, 0, 8, 0, 3);
    REQ = 2'b01;
    wait_gnt("wr1_grant");
    REQ = 2'b00;
    wait_done("wr1_done");
    check("mem0_len0", int'(mem[0]), 8'h77);
    repeat (2) @(negedge CLK);

    // Reset during the write strobe of word 2.
    wd0[0] = 8'h11; wd0[1] = 8'h22; wd0[2] = 8'h33; wd0[3] = 8'h44;
    OP = 2'b01; LEN0 = 4'd3;
    push(K_GNT, 1, 0, 0, 0);
    push(K_WD, 0, 0, 0, 0);
    push(K_WD, 1, 0, 0, 0);
    REQ = 2'b01;
    wait_gnt("rst_grant");
    REQ = 2'b00;
    n = 0;
    while (!(!WE_BAR && addr == 4'd2) && n < 2000) begin @(negedge CLK); n++; end
    if (WE_BAR || addr != 4'd2) begin
      compared++; failed++;
      $display("FAIL rst_reach_word2: actual addr %0d we_bar %0d required addr 2 we_bar 0", addr, WE_BAR);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_we_bar", int'(WE_BAR), 1);
    check("midrst_dq_oe", int'(DQ_OE), 0);
    check("midrst_counter_rst", int'(COUNTER_RST), 1);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_done", int'(DONE), 0);
    check("midrst_wd_ack", int'(WD_ACK), 0);
    check("midrst_gnt", int'(GNT), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("midrst_idle_busy", int'(BUSY), 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
